// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the router input ports, the switch allocator and the crossbar.
// master = input-port side (drives requests, reads grants); slave = allocator.
interface switch_allocator_if #(
  parameter int unsigned PORT_NUM  = 5,
  parameter int unsigned VC_NUM    = 2,
  parameter int unsigned VC_SIZE   = $clog2(VC_NUM),
  parameter int unsigned PORT_SIZE = $clog2(PORT_NUM)
);
  logic [VC_NUM-1:0]    request_i       [PORT_NUM];
  logic [PORT_SIZE-1:0] out_port_i      [PORT_NUM][VC_NUM];
  logic [VC_SIZE-1:0]   downstream_vc_i [PORT_NUM][VC_NUM];
  logic [VC_NUM-1:0]    on_off_i        [PORT_NUM];

  logic [PORT_NUM-1:0]  valid_o;
  logic [VC_SIZE-1:0]   sel_vc_o        [PORT_NUM];
  logic [PORT_NUM-1:0]  xb_valid_o;
  logic [PORT_SIZE-1:0] xb_sel_o        [PORT_NUM];
  logic [VC_SIZE-1:0]   out_vc_o        [PORT_NUM];

  modport master (
    output request_i, out_port_i, downstream_vc_i, on_off_i,
    input  valid_o, sel_vc_o, xb_valid_o, xb_sel_o, out_vc_o
  );

  modport slave (
    input  request_i, out_port_i, downstream_vc_i, on_off_i,
    output valid_o, sel_vc_o, xb_valid_o, xb_sel_o, out_vc_o
  );
endinterface

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with round-robin pointers at both stages.
// Define SA_ISLIP_EN to advance input pointers only when the nomination wins the output stage.
module switch_allocator #(
  parameter int unsigned PORT_NUM  = 5,
  parameter int unsigned VC_NUM    = 2,
  parameter int unsigned VC_SIZE   = $clog2(VC_NUM),
  parameter int unsigned PORT_SIZE = $clog2(PORT_NUM)
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave sa
);

  logic [VC_SIZE-1:0]   in_ptr_q  [PORT_NUM];
  logic [VC_SIZE-1:0]   in_ptr_d  [PORT_NUM];
  logic [PORT_SIZE-1:0] out_ptr_q [PORT_NUM];
  logic [PORT_SIZE-1:0] out_ptr_d [PORT_NUM];

  logic [VC_NUM-1:0]    elig      [PORT_NUM];
  logic [PORT_NUM-1:0]  has_nom;
  logic [VC_SIZE-1:0]   w1        [PORT_NUM];
  logic [PORT_SIZE-1:0] nom_port  [PORT_NUM];
  logic [PORT_NUM-1:0]  out_gnt;
  logic [PORT_NUM-1:0]  in_gnt;
  logic [PORT_SIZE-1:0] gnt_in    [PORT_NUM];

  // Stage 1: mask ineligible VCs, then round-robin per input from in_ptr.
  always_comb begin
    int idx;
    idx = 0;
    for (int i = 0; i < int'(PORT_NUM); i++) begin
      elig[i]     = '0;
      has_nom[i]  = 1'b0;
      w1[i]       = '0;
      nom_port[i] = '0;
      for (int v = 0; v < int'(VC_NUM); v++) begin
        // Out-of-range ports must not index on_off_i.
        if (sa.request_i[i][v] && int'(sa.out_port_i[i][v]) < int'(PORT_NUM)) begin
          elig[i][v] = sa.on_off_i[sa.out_port_i[i][v]][sa.downstream_vc_i[i][v]];
        end
      end
      for (int k = 0; k < int'(VC_NUM); k++) begin
        idx = (int'(in_ptr_q[i]) + k) % int'(VC_NUM);
        if (!has_nom[i] && elig[i][idx]) begin
          has_nom[i]  = 1'b1;
          w1[i]       = VC_SIZE'(idx);
          nom_port[i] = sa.out_port_i[i][idx];
        end
      end
    end
  end

  // Stage 2: per output, round-robin among nominating inputs from out_ptr.
  always_comb begin
    int g;
    g      = 0;
    in_gnt = '0;
    for (int o = 0; o < int'(PORT_NUM); o++) begin
      out_gnt[o] = 1'b0;
      gnt_in[o]  = '0;
      for (int k = 0; k < int'(PORT_NUM); k++) begin
        g = (int'(out_ptr_q[o]) + k) % int'(PORT_NUM);
        if (!out_gnt[o] && has_nom[g] && int'(nom_port[g]) == o) begin
          out_gnt[o] = 1'b1;
          gnt_in[o]  = PORT_SIZE'(g);
        end
      end
      if (out_gnt[o]) in_gnt[gnt_in[o]] = 1'b1;
    end
  end

  always_comb begin
    sa.valid_o    = '0;
    sa.xb_valid_o = '0;
    for (int p = 0; p < int'(PORT_NUM); p++) begin
      sa.sel_vc_o[p] = '0;
      sa.xb_sel_o[p] = '0;
      sa.out_vc_o[p] = '0;
    end
    if (!rst) begin
      for (int o = 0; o < int'(PORT_NUM); o++) begin
        if (out_gnt[o]) begin
          sa.xb_valid_o[o] = 1'b1;
          sa.xb_sel_o[o]   = gnt_in[o];
          sa.out_vc_o[o]   = sa.downstream_vc_i[gnt_in[o]][w1[gnt_in[o]]];
        end
      end
      for (int i = 0; i < int'(PORT_NUM); i++) begin
        if (in_gnt[i]) begin
          sa.valid_o[i]  = 1'b1;
          sa.sel_vc_o[i] = w1[i];
        end
      end
    end
  end

  always_comb begin
    logic adv;
    adv = 1'b0;
    for (int o = 0; o < int'(PORT_NUM); o++) begin
      out_ptr_d[o] = out_ptr_q[o];
      if (out_gnt[o]) out_ptr_d[o] = PORT_SIZE'((int'(gnt_in[o]) + 1) % int'(PORT_NUM));
    end
    for (int i = 0; i < int'(PORT_NUM); i++) begin
`ifdef SA_ISLIP_EN
      adv = in_gnt[i];
`else
      adv = has_nom[i];
`endif
      in_ptr_d[i] = in_ptr_q[i];
      if (adv) in_ptr_d[i] = VC_SIZE'((int'(w1[i]) + 1) % int'(VC_NUM));
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < int'(PORT_NUM); p++) begin
      if (rst) begin
        in_ptr_q[p]  <= '0;
        out_ptr_q[p] <= '0;
      end else begin
        in_ptr_q[p]  <= in_ptr_d[p];
        out_ptr_q[p] <= out_ptr_d[p];
      end
    end
  end

endmodule
